csr_unit_irq: RTL and testbench
===============================

// Module: csr_unit_irq
// PURPOSE
//  Machine-mode CSR file for the RV32 pipeline core, generalising the single-interrupt CSR block: NUM_IRQ prioritised
//  interrupt lines, mcause/mscratch, writable mtvec with direct/vectored mode, RW/RS/RC ops, 64-bit counters with mcountinhibit.
//  Sits beside EX stage; produces trap/mret redirect PC for IF.
// PARAMETERS
//  NUM_IRQ      1            interrupt lines, 1..16; irq[0]->MEIP(bit11,cause 11), irq[i>0]->mip[15+i](cause 15+i)
//  RESET_MTVEC  32'h0001_0000  mtvec reset value (direct mode)
//  HAS_INSTRET  1            0: minstret/minstreth read 0, writes ignored
// PORTS
//  clk            in   1    clock
//  rst            in   1    synchronous active-high reset
//  csr_addr       in   12   CSR address (read and write share it)
//  csr_op         in   2    csr_op_e: NONE=0, RW=1, RS=2, RC=3
//  csr_wdata      in   32   rs1 value / zimm
//  csr_we         in   1    write enable; decode already drops RS/RC with rs1=x0
//  csr_rdata      out  32   old value of addressed CSR (combinational)
//  csr_illegal    out  1    csr_op!=NONE and address unimplemented, or write to read-only CSR
//  irq            in   NUM_IRQ  level-sensitive interrupt requests
//  trap_ready     in   1    pipeline can take trap this cycle (no stall, valid PC)
//  trap_pc        in   32   PC saved into mepc on trap
//  mret           in   1    MRET retiring this cycle
//  instret        in   1    one instruction retired this cycle
//  irq_pending    out  1    |(mip & mie) & mstatus.MIE
//  redirect       out  1    trap taken or mret this cycle
//  redirect_pc    out  32   target PC when redirect=1, else 0
// BEHAVIOUR
//  - Reset: mstatus=0 (MPP reads 2'b11), mie=0, mtvec=RESET_MTVEC, mepc/mcause/mscratch=0, counters=0, mcountinhibit=0;
//    outputs: redirect=0, redirect_pc=0, irq_pending=0, csr_rdata per addressed reg. Reset mid-trap discards the trap.
//  - Write value: RW: wdata; RS: old|wdata; RC: old&~wdata. Update at posedge when csr_we && !csr_illegal && !take_trap.
//  - WARL: mepc[1:0]=0; mtvec.MODE writes of 2/3 keep old MODE, base[31:2] always written; mstatus only MIE(3), MPIE(7)
//    writable; mie only implemented irq bits; mip read-only (csr_illegal on write); mcountinhibit only bits 0,2.
//  - take_trap = irq_pending && trap_ready. Cause = lowest irq index pending&enabled. Same cycle (0 latency):
//    redirect=1, redirect_pc = direct ? {base,2'b00} : {base,2'b00}+4*cause. Next edge: mepc<=trap_pc&~3,
//    mcause<={1'b1,cause}, MPIE<=MIE, MIE<=0.
//  - mret (no take_trap): redirect=1, redirect_pc=mepc; edge: MIE<=MPIE, MPIE<=1.
//  - Priority same cycle: take_trap > mret > CSR write; losers dropped (pipeline flushes them).
//  - mcycle/minstret 64-bit; increment unless inhibited (mcycle: every cycle; minstret: on instret). Low-word
//    carry propagates into high word same edge (0xFFFF_FFFF -> 0, high+1). CSR write to either half wins over
//    increment for the whole counter that cycle. Wrap 2^64-1 -> 0 silently.
//  - Implemented addrs: 300,304,305,340,341,342,344,320,B00,B02,B80,B82; others -> csr_illegal=1, csr_rdata=0.
//  - csr_op=NONE: csr_rdata=0, csr_illegal=0, no write.
// STRUCTURE
//  - csr_pkg: CSR address localparams, csr_op_e, mstatus/mtvec bit positions, MODE_DIRECT/MODE_VECTORED.
//  - Sub-module csr_counter64 (inc, inhibit, wr_lo, wr_hi, wdata -> value[63:0]); instantiated for mcycle, minstret.
//  - Priority encoder for cause as a function in csr_pkg.
// TESTING
//  1 Reset then read 0x305 -> 0x0001_0000; read 0x300 -> 0x0000_1800; read 0x7C0 -> illegal=1, rdata=0.
//  2 RS 0x300 wdata 8; RS 0x304 0x800; irq[0]=1, trap_ready=1, trap_pc=0x124 -> redirect_pc=0x0001_0000;
//    next: mepc=0x124, mcause=0x8000_000B, mstatus=0x1880; mret -> redirect_pc=0x124, mstatus=0x1888.
//  3 NUM_IRQ=4, mtvec RW 0x2001, irq[3:1] all enabled+pending -> cause 16, redirect_pc=0x2040; mtvec RW 0x3 -> reads 0x1.
//  4 RW mcycle=0xFFFF_FFFE -> two cycles later mcycle=0, mcycleh=1; mcountinhibit=1 -> mcycle frozen.
//  5 trap and RW mscratch=0xDEAD same cycle -> trap taken, mscratch unchanged; trap and mret same cycle -> trap only.
//  6 irq pending, trap_ready=0 five cycles -> no redirect, no state change; rst during pending trap -> all reset values.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encoding,
// mstatus/mtvec field positions and the interrupt cause encoder.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    localparam int          MSTATUS_MIE_BIT    = 3;
    localparam int          MSTATUS_MPIE_BIT   = 7;
    localparam logic [31:0] MSTATUS_MPP_M      = 32'h0000_1800;
    localparam int          MEIP_BIT           = 11;
    localparam logic [1:0]  MODE_DIRECT        = 2'b00;
    localparam logic [1:0]  MODE_VECTORED      = 2'b01;
    localparam logic [31:0] MCOUNTINHIBIT_MASK = 32'h0000_0005;
    localparam int          MAX_IRQ            = 16;

    // Line 0 is the machine external interrupt; line i>0 lands on mip[15+i].
    function automatic logic [31:0] irq_to_mip(input logic [MAX_IRQ-1:0] lines);
        logic [31:0] mip;
        mip           = '0;
        mip[MEIP_BIT] = lines[0];
        for (int i = 1; i < MAX_IRQ; i++) begin
            mip[15+i] = lines[i];
        end
        return mip;
    endfunction

    // Lowest line index wins, so MEIP beats every platform line.
    function automatic logic [4:0] irq_cause(input logic [31:0] active);
        logic [4:0] cause;
        cause = 5'd0;
        for (int b = 30; b >= 16; b--) begin
            if (active[b]) cause = 5'(b);
        end
        if (active[MEIP_BIT]) cause = 5'(MEIP_BIT);
        return cause;
    endfunction

    function automatic logic [31:0] csr_apply_op(input csr_op_e op, input logic [31:0] old_val,
                                                 input logic [31:0] wdata);
        case (op)
            CSR_RW:  return wdata;
            CSR_RS:  return old_val | wdata;
            CSR_RC:  return old_val & ~wdata;
            default: return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit performance counter with split 32-bit write ports; a write to either
// half suppresses the increment for the whole counter that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        inhibit,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] value_q, value_d;

    always_comb begin
        // NOTE: default first so every path assigns value_d and no latch is inferred.
        value_d = value_q;
        if (wr_lo) begin
            value_d[31:0] = wdata;
        end else if (wr_hi) begin
            value_d[63:32] = wdata;
        end else if (inc && !inhibit) begin
            value_d = value_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample the same old values.
        if (rst) value_q <= '0;
        else     value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/csr_unit_irq.sv
// Machine-mode CSR file with prioritised interrupt lines, trap/mret redirect
// generation and 64-bit cycle/instret counters.
module csr_unit_irq
    import csr_pkg::*;
#(
    parameter int          NUM_IRQ     = 1,
    parameter logic [31:0] RESET_MTVEC = 32'h0001_0000,
    parameter bit          HAS_INSTRET = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic [31:0]        csr_wdata,
    input  logic               csr_we,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               trap_ready,
    input  logic [31:0]        trap_pc,
    input  logic               mret,
    input  logic               instret,
    output logic               irq_pending,
    output logic               redirect,
    output logic [31:0]        redirect_pc
);

    localparam logic [31:0] MIE_MASK = irq_to_mip(MAX_IRQ'((32'd1 << NUM_IRQ) - 32'd1));

    csr_op_e     op;
    logic        mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d, mepc_q, mepc_d, mcause_q, mcause_d, mscratch_q, mscratch_d;
    logic [31:0] mcountinhibit_q, mcountinhibit_d;
    logic [29:0] mtvec_base_q, mtvec_base_d;
    logic [1:0]  mtvec_mode_q, mtvec_mode_d;

    logic [31:0] mip, active, csr_old, wval, trap_target;
    logic [4:0]  cause;
    logic        csr_impl, take_trap, mret_take, csr_wr_en;
    logic [63:0] mcycle, minstret;

    assign op     = csr_op_e'(csr_op);
    assign mip    = irq_to_mip(MAX_IRQ'(irq));
    assign active = mip & mie_q;
    assign cause  = irq_cause(active);

    // Reset gates the control outputs so a trap in flight is simply discarded.
    assign irq_pending = !rst && mstatus_mie_q && (|active);
    assign take_trap   = irq_pending && trap_ready;
    assign mret_take   = !rst && mret && !take_trap;

    always_comb begin
        csr_impl = 1'b1;
        csr_old  = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_old                   = MSTATUS_MPP_M;
                csr_old[MSTATUS_MIE_BIT]  = mstatus_mie_q;
                csr_old[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
            end
            CSR_MIE:           csr_old = mie_q;
            CSR_MTVEC:         csr_old = {mtvec_base_q, mtvec_mode_q};
            CSR_MCOUNTINHIBIT: csr_old = mcountinhibit_q;
            CSR_MSCRATCH:      csr_old = mscratch_q;
            CSR_MEPC:          csr_old = mepc_q;
            CSR_MCAUSE:        csr_old = mcause_q;
            CSR_MIP:           csr_old = mip;
            CSR_MCYCLE:        csr_old = mcycle[31:0];
            CSR_MCYCLEH:       csr_old = mcycle[63:32];
            CSR_MINSTRET:      csr_old = minstret[31:0];
            CSR_MINSTRETH:     csr_old = minstret[63:32];
            default:           csr_impl = 1'b0;
        endcase
    end

    assign csr_illegal = (op != CSR_NONE) && (!csr_impl || (csr_we && csr_addr == CSR_MIP));
    assign csr_rdata   = (op != CSR_NONE && csr_impl) ? csr_old : 32'd0;
    assign wval        = csr_apply_op(op, csr_old, csr_wdata);
    assign csr_wr_en   = csr_we && (op != CSR_NONE) && !csr_illegal && !take_trap && !mret_take
                         && !rst;

    assign trap_target = (mtvec_mode_q == MODE_VECTORED)
                       ? {mtvec_base_q, 2'b00} + {25'd0, cause, 2'b00}
                       : {mtvec_base_q, 2'b00};
    assign redirect    = take_trap || mret_take;
    assign redirect_pc = take_trap ? trap_target : (mret_take ? mepc_q : 32'd0);

    always_comb begin
        mstatus_mie_d   = mstatus_mie_q;
        mstatus_mpie_d  = mstatus_mpie_q;
        mie_d           = mie_q;
        mtvec_base_d    = mtvec_base_q;
        mtvec_mode_d    = mtvec_mode_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        mscratch_d      = mscratch_q;
        mcountinhibit_d = mcountinhibit_q;
        if (take_trap) begin
            mepc_d         = trap_pc & ~32'd3;
            mcause_d       = {1'b1, 26'd0, cause};
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wval[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = wval[MSTATUS_MPIE_BIT];
                end
                CSR_MIE: mie_d = wval & MIE_MASK;
                CSR_MTVEC: begin
                    mtvec_base_d = wval[31:2];
                    if (wval[1:0] == MODE_DIRECT || wval[1:0] == MODE_VECTORED) begin
                        mtvec_mode_d = wval[1:0];
                    end
                end
                CSR_MCOUNTINHIBIT: mcountinhibit_d = wval & MCOUNTINHIBIT_MASK;
                CSR_MSCRATCH:      mscratch_d      = wval;
                CSR_MEPC:          mepc_d          = wval & ~32'd3;
                CSR_MCAUSE:        mcause_d        = wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q   <= 1'b0;
            mstatus_mpie_q  <= 1'b0;
            mie_q           <= '0;
            mtvec_base_q    <= RESET_MTVEC[31:2];
            mtvec_mode_q    <= RESET_MTVEC[1:0];
            mepc_q          <= '0;
            mcause_q        <= '0;
            mscratch_q      <= '0;
            mcountinhibit_q <= '0;
        end else begin
            mstatus_mie_q   <= mstatus_mie_d;
            mstatus_mpie_q  <= mstatus_mpie_d;
            mie_q           <= mie_d;
            mtvec_base_q    <= mtvec_base_d;
            mtvec_mode_q    <= mtvec_mode_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mscratch_q      <= mscratch_d;
            mcountinhibit_q <= mcountinhibit_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc     (1'b1),
        .inhibit (mcountinhibit_q[0]),
        .wr_lo   (csr_wr_en && csr_addr == CSR_MCYCLE),
        .wr_hi   (csr_wr_en && csr_addr == CSR_MCYCLEH),
        .wdata   (wval),
        .value   (mcycle)
    );

    generate
        if (HAS_INSTRET) begin : g_instret
            csr_counter64 u_minstret (
                .clk     (clk),
                .rst     (rst),
                .inc     (instret),
                .inhibit (mcountinhibit_q[2]),
                .wr_lo   (csr_wr_en && csr_addr == CSR_MINSTRET),
                .wr_hi   (csr_wr_en && csr_addr == CSR_MINSTRETH),
                .wdata   (wval),
                .value   (minstret)
            );
        end else begin : g_no_instret
            assign minstret = '0;
        end
    endgenerate

endmodule

// File: tb/tb_csr_unit_irq.sv
// Directed bench for csr_unit_irq: stimulus pushes expected outputs into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_csr_unit_irq;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        csr_we;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [3:0]  irq;
    logic        trap_ready;
    logic [31:0] trap_pc;
    logic        mret;
    logic        instret;
    logic        irq_pending;
    logic        redirect;
    logic [31:0] redirect_pc;

    csr_unit_irq #(
        .NUM_IRQ     (4),
        .RESET_MTVEC (32'h0001_0000),
        .HAS_INSTRET (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_addr    (csr_addr),
        .csr_op      (csr_op),
        .csr_wdata   (csr_wdata),
        .csr_we      (csr_we),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .irq         (irq),
        .trap_ready  (trap_ready),
        .trap_pc     (trap_pc),
        .mret        (mret),
        .instret     (instret),
        .irq_pending (irq_pending),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        ill;
        logic        redir;
        logic [31:0] rpc;
        logic        pend;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic chk = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always @(negedge clk) begin
        if (chk) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: monitor sampled with no expected entry");
            end else begin
                e = sb.pop_front();
                if (csr_rdata !== e.rdata || csr_illegal !== e.ill || redirect !== e.redir ||
                    redirect_pc !== e.rpc || irq_pending !== e.pend) begin
                    errors++;
                    $display("FAIL %s: got rdata=%h ill=%b redir=%b rpc=%h pend=%b, want rdata=%h ill=%b redir=%b rpc=%h pend=%b",
                             e.name, csr_rdata, csr_illegal, redirect, redirect_pc, irq_pending,
                             e.rdata, e.ill, e.redir, e.rpc, e.pend);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic expect_out(input string name, input logic [31:0] rdata, input logic ill,
                              input logic redir, input logic [31:0] rpc, input logic pend);
        exp_t x;
        x.name = name; x.rdata = rdata; x.ill = ill; x.redir = redir; x.rpc = rpc; x.pend = pend;
        sb.push_back(x);
        chk = 1'b1;
    endtask

    task automatic ex_rd(input string name, input logic [31:0] rdata);
        expect_out(name, rdata, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic csr(input logic [11:0] a, input csr_op_e o, input logic [31:0] wd, input logic we);
        csr_addr = a; csr_op = o; csr_wdata = wd; csr_we = we;
    endtask

    task automatic rd(input logic [11:0] a);
        csr(a, CSR_RS, 32'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk = 1'b0;
        csr_addr = '0; csr_op = CSR_NONE; csr_wdata = '0; csr_we = 1'b0;
        trap_ready = 1'b0; trap_pc = '0; mret = 1'b0; instret = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq = '0;
        csr_addr = '0; csr_op = CSR_NONE; csr_wdata = '0; csr_we = 1'b0;
        trap_ready = 1'b0; trap_pc = '0; mret = 1'b0; instret = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values and address decode
        rd(CSR_MTVEC);   ex_rd("rst_mtvec", 32'h0001_0000); tick();
        rd(CSR_MSTATUS); ex_rd("rst_mstatus", 32'h0000_1800); tick();
        rd(12'h7C0);     expect_out("unimpl_addr", 32'd0, 1'b1, 1'b0, 32'd0, 1'b0); tick();
        csr(12'h7C0, CSR_NONE, 32'hFFFF_FFFF, 1'b0); ex_rd("op_none", 32'd0); tick();
        rd(CSR_MIE);     ex_rd("rst_mie", 32'd0); tick();
        rd(CSR_MEPC);    ex_rd("rst_mepc", 32'd0); tick();
        csr(CSR_MIP, CSR_RW, 32'h1, 1'b1);
        expect_out("mip_write_illegal", 32'd0, 1'b1, 1'b0, 32'd0, 1'b0); tick();

        // Single external interrupt, direct mode, then mret
        csr(CSR_MSTATUS, CSR_RS, 32'h8, 1'b1);   ex_rd("rs_mstatus", 32'h0000_1800); tick();
        csr(CSR_MIE, CSR_RS, 32'h800, 1'b1);     ex_rd("rs_mie", 32'd0); tick();
        irq = 4'b0001; trap_ready = 1'b1; trap_pc = 32'h124; rd(CSR_MIP);
        expect_out("trap_meip", 32'h800, 1'b0, 1'b1, 32'h0001_0000, 1'b1); tick();
        irq = 4'b0000;
        rd(CSR_MEPC);    ex_rd("trap_mepc", 32'h124); tick();
        rd(CSR_MCAUSE);  ex_rd("trap_mcause", 32'h8000_000B); tick();
        rd(CSR_MSTATUS); ex_rd("trap_mstatus", 32'h0000_1880); tick();
        mret = 1'b1;     expect_out("mret_redirect", 32'd0, 1'b0, 1'b1, 32'h124, 1'b0); tick();
        rd(CSR_MSTATUS); ex_rd("mret_mstatus", 32'h0000_1888); tick();

        // Vectored mode and multi-line priority
        csr(CSR_MTVEC, CSR_RW, 32'h2001, 1'b1);  ex_rd("rw_mtvec", 32'h0001_0000); tick();
        csr(CSR_MIE, CSR_RW, 32'h0007_0000, 1'b1); ex_rd("rw_mie", 32'h800); tick();
        irq = 4'b1110; trap_ready = 1'b1; trap_pc = 32'h203;
        expect_out("trap_vec16", 32'd0, 1'b0, 1'b1, 32'h2040, 1'b1); tick();
        irq = 4'b0000;
        rd(CSR_MCAUSE);  ex_rd("mcause16", 32'h8000_0010); tick();
        rd(CSR_MEPC);    ex_rd("mepc_aligned", 32'h200); tick();
        mret = 1'b1;     expect_out("mret_aligned", 32'd0, 1'b0, 1'b1, 32'h200, 1'b0); tick();
        csr(CSR_MTVEC, CSR_RW, 32'h3, 1'b1);     ex_rd("mtvec_bad_mode_wr", 32'h2001); tick();
        rd(CSR_MTVEC);   ex_rd("mtvec_mode_kept", 32'h1); tick();
        csr(CSR_MIE, CSR_RW, 32'hFFFF_FFFF, 1'b1); ex_rd("mie_all_wr", 32'h0007_0000); tick();
        rd(CSR_MIE);     ex_rd("mie_warl", 32'h0007_0800); tick();
        csr(CSR_MSTATUS, CSR_RW, 32'hFFFF_FFFF, 1'b1); ex_rd("mstatus_all_wr", 32'h0000_1888); tick();
        rd(CSR_MSTATUS); ex_rd("mstatus_warl", 32'h0000_1888); tick();
        csr(CSR_MSTATUS, CSR_RC, 32'h8, 1'b1);   ex_rd("rc_mstatus", 32'h0000_1888); tick();
        rd(CSR_MSTATUS); ex_rd("rc_mstatus_rd", 32'h0000_1880); tick();
        csr(CSR_MSTATUS, CSR_RS, 32'h8, 1'b1);   ex_rd("rs_mstatus2", 32'h0000_1880); tick();
        irq = 4'b1001; trap_ready = 1'b1; trap_pc = 32'h300;
        expect_out("trap_vec11", 32'd0, 1'b0, 1'b1, 32'h2C, 1'b1); tick();
        irq = 4'b0000;
        rd(CSR_MCAUSE);  ex_rd("mcause11", 32'h8000_000B); tick();
        mret = 1'b1;     expect_out("mret_300", 32'd0, 1'b0, 1'b1, 32'h300, 1'b0); tick();

        // 64-bit counters: carry, inhibit, write priority
        csr(CSR_MCYCLE, CSR_RW, 32'hFFFF_FFFE, 1'b1); tick();
        rd(CSR_MCYCLE);  ex_rd("mcycle_fffe", 32'hFFFF_FFFE); tick();
        rd(CSR_MCYCLE);  ex_rd("mcycle_ffff", 32'hFFFF_FFFF); tick();
        rd(CSR_MCYCLE);  ex_rd("mcycle_wrap", 32'd0); tick();
        rd(CSR_MCYCLEH); ex_rd("mcycleh_carry", 32'd1); tick();
        csr(CSR_MCOUNTINHIBIT, CSR_RW, 32'hFFFF_FFFF, 1'b1); ex_rd("inhibit_wr", 32'd0); tick();
        rd(CSR_MCOUNTINHIBIT); ex_rd("inhibit_warl", 32'h5); tick();
        csr(CSR_MCYCLE, CSR_RW, 32'h10, 1'b1); tick();
        rd(CSR_MCYCLE);  ex_rd("mcycle_frozen1", 32'h10); tick();
        rd(CSR_MCYCLE);  ex_rd("mcycle_frozen2", 32'h10); tick();
        csr(CSR_MCYCLEH, CSR_RW, 32'h7, 1'b1); ex_rd("mcycleh_wr", 32'd1); tick();
        rd(CSR_MCYCLEH); ex_rd("mcycleh_rd", 32'h7); tick();
        rd(CSR_MCYCLE);  ex_rd("mcycle_lo_kept", 32'h10); tick();
        instret = 1'b1; rd(CSR_MINSTRET); ex_rd("minstret_inhib", 32'd0); tick();
        csr(CSR_MCOUNTINHIBIT, CSR_RW, 32'd0, 1'b1); ex_rd("inhibit_clr", 32'h5); tick();
        instret = 1'b1; csr(CSR_MINSTRET, CSR_RW, 32'hFFFF_FFFF, 1'b1);
        ex_rd("minstret_wr", 32'd0); tick();
        instret = 1'b1; rd(CSR_MINSTRET); ex_rd("minstret_wr_wins", 32'hFFFF_FFFF); tick();
        rd(CSR_MINSTRET);  ex_rd("minstret_wrap", 32'd0); tick();
        rd(CSR_MINSTRETH); ex_rd("minstreth_carry", 32'd1); tick();

        // Same-cycle priority: trap > mret > CSR write
        csr(CSR_MSCRATCH, CSR_RW, 32'h1234, 1'b1); ex_rd("mscratch_wr", 32'd0); tick();
        irq = 4'b0100; trap_ready = 1'b1; trap_pc = 32'h400;
        csr(CSR_MSCRATCH, CSR_RW, 32'hDEAD, 1'b1);
        expect_out("trap_vs_write", 32'h1234, 1'b0, 1'b1, 32'h44, 1'b1); tick();
        irq = 4'b0000;
        rd(CSR_MSCRATCH); ex_rd("mscratch_kept", 32'h1234); tick();
        mret = 1'b1;      expect_out("mret_400", 32'd0, 1'b0, 1'b1, 32'h400, 1'b0); tick();
        irq = 4'b1000; trap_ready = 1'b1; mret = 1'b1; trap_pc = 32'h500;
        expect_out("trap_vs_mret", 32'd0, 1'b0, 1'b1, 32'h48, 1'b1); tick();
        irq = 4'b0000;
        rd(CSR_MSTATUS); ex_rd("trap_won_mstatus", 32'h0000_1880); tick();
        rd(CSR_MEPC);    ex_rd("trap_won_mepc", 32'h500); tick();
        rd(CSR_MCAUSE);  ex_rd("trap_won_mcause", 32'h8000_0012); tick();
        mret = 1'b1; csr(CSR_MSCRATCH, CSR_RW, 32'hBEEF, 1'b1);
        expect_out("mret_vs_write", 32'h1234, 1'b0, 1'b1, 32'h500, 1'b0); tick();
        rd(CSR_MSCRATCH); ex_rd("mret_won_mscratch", 32'h1234); tick();
        rd(CSR_MSTATUS);  ex_rd("mret_won_mstatus", 32'h0000_1888); tick();

        // Pending but pipeline not ready, then reset while a trap is due
        irq = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            rd(CSR_MEPC); expect_out("hold_not_ready", 32'h500, 1'b0, 1'b0, 32'd0, 1'b1); tick();
        end
        rd(CSR_MCAUSE); expect_out("hold_mcause", 32'h8000_0012, 1'b0, 1'b0, 32'd0, 1'b1); tick();
        rst = 1'b1; trap_ready = 1'b1; trap_pc = 32'h600;
        expect_out("rst_mid_trap", 32'd0, 1'b0, 1'b0, 32'd0, 1'b0); tick();
        irq = 4'b0000;
        rd(CSR_MTVEC);         ex_rd("post_rst_mtvec", 32'h0001_0000); tick();
        rd(CSR_MSTATUS);       ex_rd("post_rst_mstatus", 32'h0000_1800); tick();
        rd(CSR_MEPC);          ex_rd("post_rst_mepc", 32'd0); tick();
        rd(CSR_MCAUSE);        ex_rd("post_rst_mcause", 32'd0); tick();
        rd(CSR_MSCRATCH);      ex_rd("post_rst_mscratch", 32'd0); tick();
        rd(CSR_MIE);           ex_rd("post_rst_mie", 32'd0); tick();
        rd(CSR_MCOUNTINHIBIT); ex_rd("post_rst_inhibit", 32'd0); tick();
        rd(CSR_MCYCLEH);       ex_rd("post_rst_mcycleh", 32'd0); tick();
        rd(CSR_MINSTRETH);     ex_rd("post_rst_minstreth", 32'd0); tick();

        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
